// File: rtl/floating_add_cmp_conv.sv
// floating_add_cmp_conv
//   Single-cycle IEEE-754 binary32 unit. Each accepted operation is computed
//   combinationally from the sampled inputs and registered on the same edge.
//   Supported operations are add, subtract, signed-int-to-float and compare.
//   Denormal inputs and results are flushed to signed zero. Rounding is
//   round-to-nearest-even.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous active-high reset; wins over enable
//   enable  in   1   launches one operation on the edge where it is 1
//   op      in   2   00 add, 01 subtract, 10 int-to-float, 11 compare
//   a       in  32   float operand, or signed integer when op=10
//   b       in  32   float operand; ignored when op=10
//   result  out 32   registered float result; held by compare and idle cycles
//   cmp     out  2   registered compare: 00 eq, 01 lt, 11 gt, 10 unordered
//   valid   out  1   high for the one cycle after each accepted operation
//   debug   out 32   {26'b0, nan, inexact, flush, overflow, op}
module floating_add_cmp_conv (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [1:0]  cmp,
    output logic        valid,
    output logic [31:0] debug
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CVT = 2'b10;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_UN = 2'b10;
    localparam logic [1:0] CMP_GT = 2'b11;

    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
        logic        ftz;
        logic        inx;
        logic        nan;
    } fp_res_t;

    // Position of the most significant set bit (0 when v is zero).
    function automatic logic [4:0] msb_pos32(input logic [31:0] v);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) p = i[4:0];
        end
        return p;
    endfunction

    // Round-to-nearest-even on a normalised significand.
    //   n[26]   hidden bit (always 1 here)
    //   n[25:3] fraction
    //   n[2]    guard, n[1] round, n[0] sticky
    // Returns {carry, fraction}; carry means the significand rolled over to
    // 2.0 and the exponent must be bumped (fraction is then zero).
    function automatic logic [23:0] round_rne(input logic [26:0] n);
        logic        up;
        logic [24:0] t;
        up = n[2] & (n[1] | n[0] | n[3]);
        t  = {1'b0, n[26:3]} + {24'd0, up};
        // On rollover the hidden bit position drops to 0 while bit 24 rises.
        return {t[24] & ~t[23], t[22:0]};
    endfunction

    // Add (sub=0) or subtract (sub=1) two binary32 values.
    function automatic fp_res_t add_core(input logic [31:0] x, input logic [31:0] y,
                                         input logic sub);
        fp_res_t            r;
        logic               sx, sy, x_den, y_den, x_nan, y_nan, x_inf, y_inf;
        logic [7:0]         ex, ey, e_big, e_small, d;
        logic [22:0]        mx, my, f_big, f_small;
        logic               s_big, s_small, swap;
        logic [23:0]        m_big, m_small, rm;
        logic [49:0]        wide;
        logic [26:0]        xa, ya, n;
        logic [27:0]        sum;
        logic [4:0]         pos, lz;
        logic signed [9:0]  e_res, e_fin;

        r = '0;
        sx = x[31];        ex = x[30:23]; mx = x[22:0];
        sy = y[31] ^ sub;  ey = y[30:23]; my = y[22:0];
        x_den = (ex == 8'd0) && (mx != 23'd0);
        y_den = (ey == 8'd0) && (my != 23'd0);
        x_nan = (ex == 8'hFF) && (mx != 23'd0);
        y_nan = (ey == 8'hFF) && (my != 23'd0);
        x_inf = (ex == 8'hFF) && (mx == 23'd0);
        y_inf = (ey == 8'hFF) && (my == 23'd0);
        if (x_den) mx = '0;
        if (y_den) my = '0;
        r.ftz = x_den | y_den;

        swap = '0; s_big = '0; s_small = '0; e_big = '0; e_small = '0;
        f_big = '0; f_small = '0; m_big = '0; m_small = '0; d = '0;
        wide = '0; xa = '0; ya = '0; n = '0; sum = '0; pos = '0; lz = '0;
        rm = '0; e_res = '0; e_fin = '0;

        if (x_nan || y_nan) begin
            r.val = QNAN;
            r.nan = 1'b1;
        end else if (x_inf && y_inf) begin
            if (sx == sy) begin
                r.val = {sx, 8'hFF, 23'd0};
            end else begin
                r.val = QNAN;
                r.nan = 1'b1;
            end
        end else if (x_inf) begin
            r.val = {sx, 8'hFF, 23'd0};
        end else if (y_inf) begin
            r.val = {sy, 8'hFF, 23'd0};
        end else begin
            // Order operands by magnitude so the difference is never negative.
            swap = {ey, my} > {ex, mx};
            if (swap) begin
                s_big = sy; e_big = ey; f_big = my;
                s_small = sx; e_small = ex; f_small = mx;
            end else begin
                s_big = sx; e_big = ex; f_big = mx;
                s_small = sy; e_small = ey; f_small = my;
            end
            m_big   = {e_big != 8'd0, f_big};
            m_small = {e_small != 8'd0, f_small};
            d       = e_big - e_small;

            // Align the smaller operand keeping guard, round and sticky bits.
            xa = {m_big, 3'b000};
            if (d > 8'd26) begin
                ya = {26'd0, m_small != 24'd0};
            end else begin
                wide = {m_small, 26'd0} >> d;
                ya   = {wide[49:24], |wide[23:0]};
            end

            if (s_big == s_small) sum = {1'b0, xa} + {1'b0, ya};
            else                  sum = {1'b0, xa} - {1'b0, ya};

            if (sum == 28'd0) begin
                // Exact cancellation is +0 unless both addends were negative.
                r.val = {sx & sy, 31'd0};
            end else begin
                if (sum[27]) begin
                    n     = {sum[27:2], sum[1] | sum[0]};
                    e_res = $signed({2'b00, e_big}) + 10'sd1;
                end else begin
                    pos   = msb_pos32({5'd0, sum[26:0]});
                    lz    = 5'd26 - pos;
                    n     = sum[26:0] << lz;
                    e_res = $signed({2'b00, e_big}) - $signed({5'd0, lz});
                end
                r.inx = |n[2:0];
                if (e_res <= 10'sd0) begin
                    r.val = {s_big, 31'd0};
                    r.ftz = 1'b1;
                    r.inx = 1'b1;
                end else begin
                    rm    = round_rne(n);
                    e_fin = e_res + $signed({9'd0, rm[23]});
                    if (e_fin >= 10'sd255) begin
                        r.val = {s_big, 8'hFF, 23'd0};
                        r.ovf = 1'b1;
                        r.inx = 1'b1;
                    end else begin
                        r.val = {s_big, e_fin[7:0], rm[22:0]};
                    end
                end
            end
        end
        return r;
    endfunction

    // Signed 32-bit integer to binary32; cannot overflow.
    function automatic fp_res_t cvt_core(input logic [31:0] x);
        fp_res_t     r;
        logic [31:0] mag, norm;
        logic [4:0]  p;
        logic [7:0]  e;
        logic [23:0] rm;

        r    = '0;
        mag  = x[31] ? (32'd0 - x) : x;
        p    = msb_pos32(mag);
        norm = mag << (5'd31 - p);
        e    = 8'd127 + {3'd0, p};
        rm   = '0;
        if (mag != 32'd0) begin
            rm    = round_rne({norm[31:6], |norm[5:0]});
            r.inx = norm[7] | norm[6] | (|norm[5:0]);
            r.val = {x[31], e + {7'd0, rm[23]}, rm[22:0]};
        end
        return r;
    endfunction

    // Compare; returns {nan, ftz, cmp[1:0]}.
    function automatic logic [3:0] cmp_core(input logic [31:0] x, input logic [31:0] y);
        logic        sx, sy, x_nan, y_nan, x_den, y_den, x_zero, y_zero;
        logic [30:0] magx, magy;
        logic [1:0]  c;

        sx     = x[31];
        sy     = y[31];
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        x_den  = (x[30:23] == 8'd0) && (x[22:0] != 23'd0);
        y_den  = (y[30:23] == 8'd0) && (y[22:0] != 23'd0);
        x_zero = x[30:23] == 8'd0;
        y_zero = y[30:23] == 8'd0;
        magx   = x_zero ? 31'd0 : x[30:0];
        magy   = y_zero ? 31'd0 : y[30:0];

        if (x_nan || y_nan)             c = CMP_UN;
        else if (x_zero && y_zero)      c = CMP_EQ;
        else if (sx != sy)              c = sx ? CMP_LT : CMP_GT;
        else if (magx == magy)          c = CMP_EQ;
        // For two negatives the magnitude order is reversed.
        else if ((magx < magy) ^ sx)    c = CMP_LT;
        else                            c = CMP_GT;

        return {x_nan | y_nan, x_den | y_den, c};
    endfunction

    logic [31:0] result_q, result_d;
    logic [1:0]  cmp_q, cmp_d;
    logic        valid_q, valid_d;
    logic [31:0] debug_q, debug_d;

    fp_res_t     add_r, cvt_r;
    logic [3:0]  cmp_r;

    always_comb begin
        add_r = add_core(a, b, op == OP_SUB);
        cvt_r = cvt_core(a);
        cmp_r = cmp_core(a, b);

        result_d = result_q;
        cmp_d    = cmp_q;
        debug_d  = debug_q;
        valid_d  = 1'b0;

        if (enable) begin
            valid_d = 1'b1;
            case (op)
                OP_ADD, OP_SUB: begin
                    result_d = add_r.val;
                    debug_d  = {26'd0, add_r.nan, add_r.inx, add_r.ftz, add_r.ovf, op};
                end
                OP_CVT: begin
                    result_d = cvt_r.val;
                    debug_d  = {26'd0, cvt_r.nan, cvt_r.inx, cvt_r.ftz, cvt_r.ovf, op};
                end
                default: begin
                    cmp_d   = cmp_r[1:0];
                    debug_d = {26'd0, cmp_r[3], 1'b0, cmp_r[2], 1'b0, op};
                end
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            cmp_q    <= '0;
            valid_q  <= 1'b0;
            debug_q  <= '0;
        end else begin
            result_q <= result_d;
            cmp_q    <= cmp_d;
            valid_q  <= valid_d;
            debug_q  <= debug_d;
        end
    end

    assign result = result_q;
    assign cmp    = cmp_q;
    assign valid  = valid_q;
    assign debug  = debug_q;

endmodule

// File: tb/tb_floating_add_cmp_conv.sv
// Directed-vector bench for floating_add_cmp_conv. Inputs change on the
// falling edge; outputs are sampled on the following falling edge.
module tb_floating_add_cmp_conv;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [1:0]  cmp;
    logic        valid;
    logic [31:0] debug;

    int n_checks = 0;
    int n_errors = 0;

    floating_add_cmp_conv dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .cmp    (cmp),
        .valid  (valid),
        .debug  (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One enabled cycle; returns on the falling edge after the capture edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        enable = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic idle_check(input string tag, input logic [31:0] r, input logic [1:0] c,
                              input logic [31:0] d);
        @(negedge clk);
        check_eq({tag, "_valid_low"}, 32'(valid), 32'd0);
        check_eq({tag, "_result_hold"}, result, r);
        check_eq({tag, "_cmp_hold"}, 32'(cmp), 32'(c));
        check_eq({tag, "_debug_hold"}, debug, d);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_result", result, 32'h0000_0000);
        check_eq("rst_cmp", 32'(cmp), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_debug", debug, 32'h0000_0000);
        reset = 1'b0;

        // 1.0 + 2.0 = 3.0
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000);
        check_eq("add12_valid", 32'(valid), 32'd1);
        check_eq("add12_result", result, 32'h4040_0000);
        check_eq("add12_debug", debug, 32'h0000_0000);
        check_eq("add12_cmp", 32'(cmp), 32'd0);
        idle_check("add12_idle", 32'h4040_0000, 2'b00, 32'h0000_0000);

        // 1.0 - 1.0 = +0
        issue(2'b01, 32'h3F80_0000, 32'h3F80_0000);
        check_eq("sub11_result", result, 32'h0000_0000);
        check_eq("sub11_debug", debug, 32'h0000_0001);

        // 2.0 - 1.5 = 0.5 (normalising left shift)
        issue(2'b01, 32'h4000_0000, 32'h3FC0_0000);
        check_eq("sub_norm_result", result, 32'h3F00_0000);

        // (-0) + (-0) = -0
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        check_eq("negzero_result", result, 32'h8000_0000);

        // 1.0 + 2^-24 is an exact tie: stays at even 1.0, inexact
        issue(2'b00, 32'h3F80_0000, 32'h3380_0000);
        check_eq("tie_even_result", result, 32'h3F80_0000);
        check_eq("tie_even_debug", debug, 32'h0000_0010);
        // (1+2^-23) + 2^-24 ties upward to the even neighbour
        issue(2'b00, 32'h3F80_0001, 32'h3380_0000);
        check_eq("tie_up_result", result, 32'h3F80_0002);

        // Denormal input treated as zero
        issue(2'b00, 32'h0000_0001, 32'h3F80_0000);
        check_eq("den_in_result", result, 32'h3F80_0000);
        check_eq("den_in_debug", debug, 32'h0000_0008);

        // Denormal result flushes to -0
        issue(2'b01, 32'h0080_0000, 32'h0080_0001);
        check_eq("den_out_result", result, 32'h8000_0000);
        check_eq("den_out_ftz", 32'(debug[3]), 32'd1);

        // -inf + 1.0 = -inf
        issue(2'b00, 32'hFF80_0000, 32'h3F80_0000);
        check_eq("inf_fin_result", result, 32'hFF80_0000);

        // Conversions
        issue(2'b10, 32'hFFFF_FFFB, 32'h1234_5678);
        check_eq("cvt_m5_result", result, 32'hC0A0_0000);
        check_eq("cvt_m5_debug", debug, 32'h0000_0002);
        issue(2'b10, 32'd16777217, 32'h0);
        check_eq("cvt_tie_result", result, 32'h4B80_0000);
        check_eq("cvt_tie_debug", debug, 32'h0000_0012);
        issue(2'b10, 32'h0000_0000, 32'h0);
        check_eq("cvt_zero_result", result, 32'h0000_0000);
        issue(2'b10, 32'h8000_0000, 32'h0);
        check_eq("cvt_min_result", result, 32'hCF00_0000);

        // Compares leave result at 0xCF000000
        issue(2'b11, 32'h3F80_0000, 32'h4000_0000);
        check_eq("cmp_lt", 32'(cmp), 32'(2'b01));
        check_eq("cmp_lt_result", result, 32'hCF00_0000);
        check_eq("cmp_lt_debug", debug, 32'h0000_0003);
        issue(2'b11, 32'h4000_0000, 32'h3F80_0000);
        check_eq("cmp_gt", 32'(cmp), 32'(2'b11));
        issue(2'b11, 32'h0000_0000, 32'h8000_0000);
        check_eq("cmp_zeros", 32'(cmp), 32'(2'b00));
        issue(2'b11, 32'hBF80_0000, 32'hC000_0000);
        check_eq("cmp_neg_gt", 32'(cmp), 32'(2'b11));
        issue(2'b11, 32'h7FC0_0000, 32'h3F80_0000);
        check_eq("cmp_nan", 32'(cmp), 32'(2'b10));
        check_eq("cmp_nan_debug", debug, 32'h0000_0023);
        check_eq("cmp_nan_result", result, 32'hCF00_0000);

        // Overflow and invalid; cmp must stay at 10
        issue(2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        check_eq("ovf_result", result, 32'h7F80_0000);
        check_eq("ovf_flag", 32'(debug[2]), 32'd1);
        check_eq("ovf_cmp_hold", 32'(cmp), 32'(2'b10));
        issue(2'b01, 32'h7F80_0000, 32'h7F80_0000);
        check_eq("infsub_result", result, 32'h7FC0_0000);
        check_eq("infsub_nan", 32'(debug[5]), 32'd1);
        check_eq("infsub_op", 32'(debug[1:0]), 32'(2'b01));

        // Reset and enable on the same edge: operation discarded
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        op     = 2'b00;
        a      = 32'h3F80_0000;
        b      = 32'h4000_0000;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        check_eq("rstpri_result", result, 32'h0000_0000);
        check_eq("rstpri_cmp", 32'(cmp), 32'd0);
        check_eq("rstpri_valid", 32'(valid), 32'd0);
        check_eq("rstpri_debug", debug, 32'h0000_0000);
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000);
        check_eq("post_rst_valid", 32'(valid), 32'd1);
        check_eq("post_rst_result", result, 32'h4040_0000);

        // Back-to-back: add, compare, convert
        @(negedge clk);
        enable = 1'b1; op = 2'b00; a = 32'h4000_0000; b = 32'h3F80_0000;
        @(negedge clk);
        check_eq("b2b_add_valid", 32'(valid), 32'd1);
        check_eq("b2b_add_result", result, 32'h4040_0000);
        op = 2'b11; a = 32'h3F80_0000; b = 32'h4000_0000;
        @(negedge clk);
        check_eq("b2b_cmp_valid", 32'(valid), 32'd1);
        check_eq("b2b_cmp", 32'(cmp), 32'(2'b01));
        check_eq("b2b_cmp_result", result, 32'h4040_0000);
        op = 2'b10; a = 32'hFFFF_FFFB; b = 32'h0;
        @(negedge clk);
        enable = 1'b0;
        check_eq("b2b_cvt_valid", 32'(valid), 32'd1);
        check_eq("b2b_cvt_result", result, 32'hC0A0_0000);
        check_eq("b2b_cvt_cmp", 32'(cmp), 32'(2'b01));
        check_eq("b2b_cvt_debug", debug, 32'h0000_0002);
        a = 32'h1111_1111; b = 32'h2222_2222; op = 2'b00;
        idle_check("b2b_idle1", 32'hC0A0_0000, 2'b01, 32'h0000_0002);
        idle_check("b2b_idle2", 32'hC0A0_0000, 2'b01, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
